// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: fixed-priority interrupt arbiter with request/ack handshake and in-service tracking; nesting via INT_NESTING_EN
//   ports: clock, nreset (async active-low), irq_in, irq_edge_sel, control_reg[0]=global enable, mask_reg,
//          pending_clr (W1C pulse), int_ack, int_return -> interrupt, int_vec_addr, pending, in_service
module interrupt_arbiter #(
  parameter int                NUM_SRC  = 8,
  parameter int                ADDR_W   = 14,
  parameter logic [ADDR_W-1:0] VEC_BASE = 14'h0001
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_edge_sel,
  input  logic [7:0]         control_reg,
  input  logic [NUM_SRC-1:0] mask_reg,
  input  logic [NUM_SRC-1:0] pending_clr,
  input  logic               int_ack,
  input  logic               int_return,
  output logic               interrupt,
  output logic [ADDR_W-1:0]  int_vec_addr,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service
);
  localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;
  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] irq_prev_q, pending_q, pending_d, in_service_q, in_service_d;
  logic [NUM_SRC-1:0] event_v, eligible, ack_bit, ret_bit;
  logic [IW-1:0]      win_q, win_d, win_idx;
  logic               ack;
  function automatic logic [IW-1:0] low_idx(input logic [NUM_SRC-1:0] v);
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (v[i]) low_idx = IW'(i);
  endfunction
  always_comb begin
    event_v      = irq_in & ~(irq_edge_sel & irq_prev_q);
    eligible     = pending_q & mask_reg & {NUM_SRC{control_reg[0]}};
    win_idx      = low_idx(eligible);
    ack          = state_q == REQUEST && int_ack;
    ack_bit      = ack ? NUM_SRC'(1) << win_q : '0;
    // isolate the lowest set in_service bit
    ret_bit      = int_return ? in_service_q & (~in_service_q + NUM_SRC'(1)) : '0;
    // a new event overrides any clear in the same cycle
    pending_d    = (pending_q & ~(pending_clr | ack_bit)) | event_v;
    in_service_d = (in_service_q & ~ret_bit) | ack_bit;
    state_d      = state_q;
    win_d        = win_q;
    case (state_q)
      IDLE: if (|eligible) begin
        state_d = REQUEST;
        win_d   = win_idx;
      end
      REQUEST:
        if (ack) state_d = SERVICE;
        else if (!control_reg[0] || !mask_reg[win_q]) state_d = |in_service_d ? SERVICE : IDLE;
      SERVICE:
        if (!(|in_service_d)) state_d = IDLE;
`ifdef INT_NESTING_EN
        else if (|eligible && win_idx < low_idx(in_service_q)) begin
          state_d = REQUEST;
          win_d   = win_idx;
        end
`else
        else state_d = SERVICE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      win_q        <= '0;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      irq_prev_q   <= irq_in;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end
  assign interrupt    = state_q == REQUEST;
  assign int_vec_addr = interrupt ? VEC_BASE + ADDR_W'(win_q) : '0;
  assign pending      = pending_q;
  assign in_service   = in_service_q;
endmodule

// File: doc/interrupt_arbiter.md
Name: interrupt_arbiter

Overview:
- Prioritising interrupt arbiter and sequencer between the SoC interrupt sources and the hazard control unit.
- Latches source events into a pending register, applies the SFR mask and global enable, and selects one winner by fixed priority.
- Presents the winner's vector to the core with a request/acknowledge handshake, then tracks it as in-service until the return-from-interrupt is signalled.

Parameters:
- NUM_SRC, 8, number of interrupt sources. Index 0 has highest priority.
- ADDR_W, 14, width of the vector address.
- VEC_BASE, 14'h0001, vector for source 0. Source i uses VEC_BASE+i, modulo 2^ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- nreset  in  1  reset, asynchronous, active-low.
- irq_in  in  NUM_SRC  raw source lines, synchronous to clock.
- irq_edge_sel  in  NUM_SRC  per source: 1 = rising-edge triggered, 0 = level triggered.
- control_reg  in  8  SFR control. Bit 0 = global interrupt enable; other bits ignored.
- mask_reg  in  NUM_SRC  per-source enable, 1 = enabled.
- pending_clr  in  NUM_SRC  SFR write-one-to-clear pulse for pending bits.
- int_ack  in  1  one-cycle pulse from the hazard unit: vector accepted.
- int_return  in  1  one-cycle pulse: RETI executed.
- interrupt  out  1  interrupt request to the hazard unit.
- int_vec_addr  out  ADDR_W  vector of the current request; 0 when no request.
- pending  out  NUM_SRC  pending status for SFR readback.
- in_service  out  NUM_SRC  in-service status.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; interrupt=0; int_vec_addr=0; pending=0; in_service=0; edge history=0.
- Event detection, per source, each cycle:
  - Edge mode: event = irq_in & ~irq_prev.
  - Level mode: event = irq_in.
  - irq_prev registers irq_in every cycle, including while disabled.
- Pending update, per bit: next = (pending & ~clear) | event.
  - clear = pending_clr, plus the winner bit on int_ack.
  - A set wins over a clear in the same cycle.
  - Masked sources still latch pending.
- Eligible set = pending & mask_reg, gated by control_reg[0]. Winner = lowest eligible index.
- IDLE:
  - If any source is eligible, go to REQUEST on the next edge.
  - On that edge, register the winner index, set interrupt=1 and int_vec_addr=VEC_BASE+winner.
  - Latency: irq_in first sampled high at edge k → pending at k → interrupt at k+1.
- REQUEST:
  - interrupt and int_vec_addr hold stable until int_ack.
  - The winner is frozen. A higher-priority source arriving now waits for the next arbitration.
  - int_ack → clear that pending bit, set in_service[winner], interrupt=0, int_vec_addr=0, go to SERVICE.
  - If control_reg[0] drops or mask_reg[winner] clears before ack: withdraw the request (interrupt=0, vector=0), keep pending, go back to IDLE (or SERVICE if in_service≠0).
  - int_ack and withdraw in the same cycle: ack wins.
- SERVICE:
  - New requests are blocked (see optional feature).
  - int_return clears the highest-priority set in_service bit (lowest index).
  - If in_service becomes 0, go to IDLE; arbitration resumes the following cycle, with no back-to-back request in the return cycle.
- Stray handshakes:
  - int_ack outside REQUEST is ignored.
  - int_return with in_service=0 is ignored.
  - int_return during REQUEST applies to in_service only; the request stays up.
- pending_clr on the frozen winner during REQUEST does not withdraw the request. The ack clears the bit anyway.

Optional Feature:
- Macro INT_NESTING_EN.
- When defined:
  - In SERVICE, an eligible source with index strictly lower than the lowest set in_service bit raises a new REQUEST (preemption).
  - Multiple in_service bits may be set. Each int_return retires the lowest-index bit.
  - State returns to SERVICE while in_service≠0.
- When undefined: in_service is at most one-hot, and no request is issued while in_service≠0.

Test Plan:
- Reset mid-REQUEST: nreset low asynchronously while interrupt=1 → interrupt=0, int_vec_addr=0, pending=0 immediately, without waiting for a clock edge.
- Single edge: control_reg=8'h01, mask_reg=8'hFF, irq_in[2] rises at edge k → pending=8'h04 at k, interrupt=1 and int_vec_addr=14'h0003 at k+1. Ack → in_service=8'h04, pending=0. int_return → in_service=0.
- Priority: irq_in[5] and irq_in[1] rise in the same cycle → vector 14'h0002 first. After ack and return, vector 14'h0006 is issued. pending[5] stays set throughout.
- Masking and withdraw: mask_reg=8'hFE with source 0 pending → no request. Request on source 3, then control_reg=8'h00 before ack → interrupt drops the next edge, pending[3] stays 1, and re-enabling re-requests 14'h0004.
- Set/clear race: int_ack for source 4 in the same cycle as a new rising edge on irq_in[4] → pending[4]=1 and in_service[4]=1.
- INT_NESTING_EN: source 6 in service, source 2 rises → new request with vector 14'h0003, in_service=8'h44. First return → 8'h40, second return → 8'h00. Without the macro: no request until the first return.
